// File: rtl/idex_hazard_stage_pkg.sv
// Shared pipeline definitions: control-word packing and register constants.
// The forwarding unit and the MEM stage decode the same control word.
package pipe_defs;

    // Control word {regwrite,memread,memwrite,memtoreg,alusrc,regdst,aluop[1:0]}
    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP    = 0;
    localparam int CTRL_ALUOP_W  = 2;

    // $0 is hardwired to zero, so a load targeting it never creates a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Control word carried by an injected bubble: nothing writes anything
    function automatic ctrl_t bubble_ctrl();
        return '0;
    endfunction

endpackage

// File: rtl/idex_hazard_stage_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID must be separated from it by one bubble.
module load_use_detect
    import pipe_defs::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              idex_valid,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    output logic              hz
);

    logic load_in_ex;
    logic rs_match;
    logic rt_match;

    // Only a real load writing a non-zero register can hazard; rt counts only when read
    always_comb begin
        load_in_ex = idex_valid & idex_memread & (idex_rt != REG_AW'(REG_ZERO));
        rs_match   = (idex_rt == id_rs);
        rt_match   = id_uses_rt & (idex_rt == id_rt);
        hz         = load_in_ex & id_valid & (rs_match | rt_match);
    end

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use stall and bubble injection.
// A flush or a hazard replaces the incoming instruction with a bubble;
// every bubble is counted in a saturating counter.
module idex_hazard_stage
    import pipe_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    output logic              stall,
    output logic              idex_valid,
    output logic [REG_AW-1:0] idex_rs,
    output logic [REG_AW-1:0] idex_rt,
    output logic [REG_AW-1:0] idex_rd,
    output logic [DATA_W-1:0] idex_rs_data,
    output logic [DATA_W-1:0] idex_rt_data,
    output logic [DATA_W-1:0] idex_imm,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q,   valid_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    ctrl_t             ctrl_q,    ctrl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic hz;
    logic bubble;

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .idex_valid   (valid_q),
        .idex_memread (ctrl_q[CTRL_MEMREAD]),
        .idex_rt      (rt_q),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .hz           (hz)
    );

    // Flush wins over stall: the ID instruction is being discarded, so no need to hold it
    assign stall  = hz & ~flush;
    assign bubble = flush | hz;

    // Next state: bubble on flush/hazard (operands held), otherwise capture ID
    always_comb begin
        valid_d   = valid_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        ctrl_d    = ctrl_q;
        if (bubble) begin
            valid_d = 1'b0;
            ctrl_d  = bubble_ctrl();
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
        end else begin
            valid_d   = id_valid;
            ctrl_d    = id_valid ? id_ctrl : bubble_ctrl();
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
        end
        cnt_d = (bubble && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Pipeline register and bubble counter, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign idex_valid   = valid_q;
    assign idex_rs      = rs_q;
    assign idex_rt      = rt_q;
    assign idex_rd      = rd_q;
    assign idex_rs_data = rs_data_q;
    assign idex_rt_data = rt_data_q;
    assign idex_imm     = imm_q;
    assign idex_ctrl    = ctrl_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Bench for idex_hazard_stage: directed load-use / flush / saturation / reset
// scenarios followed by random traffic, checked every cycle against a model.
module tb_idex_hazard_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_uses_rt = 1'b0;
    logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [7:0]  id_ctrl = '0;
    logic        flush = 1'b0;

    logic        stall, idex_valid;
    logic [4:0]  idex_rs, idex_rt, idex_rd;
    logic [31:0] idex_rs_data, idex_rt_data, idex_imm;
    logic [7:0]  idex_ctrl;
    logic [15:0] bubble_cnt;

    logic        s_stall, s_valid;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [31:0] s_rs_data, s_rt_data, s_imm;
    logic [7:0]  s_ctrl;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    idex_hazard_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush),
        .stall(stall), .idex_valid(idex_valid), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .idex_rd(idex_rd), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
        .idex_imm(idex_imm), .idex_ctrl(idex_ctrl), .bubble_cnt(bubble_cnt)
    );

    idex_hazard_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush),
        .stall(s_stall), .idex_valid(s_valid), .idex_rs(s_rs), .idex_rt(s_rt),
        .idex_rd(s_rd), .idex_rs_data(s_rs_data), .idex_rt_data(s_rt_data),
        .idex_imm(s_imm), .idex_ctrl(s_ctrl), .bubble_cnt(s_cnt)
    );

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic [4:0]  m_rs = '0, m_rt = '0, m_rd = '0;
    logic [31:0] m_rs_data = '0, m_rt_data = '0, m_imm = '0;
    logic [7:0]  m_ctrl = '0;
    int          m_bubbles = 0;

    // A load (ctrl bit 6) in EX writing a nonzero register read by the valid ID instruction
    function automatic logic model_hz();
        logic dep;
        dep = (m_rt == id_rs) || (id_uses_rt && (m_rt == id_rt));
        return m_valid && m_ctrl[6] && (m_rt != 5'd0) && id_valid && dep;
    endfunction

    function automatic logic model_stall();
        return model_hz() && !flush;
    endfunction

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_rs <= '0; m_rt <= '0; m_rd <= '0;
            m_rs_data <= '0; m_rt_data <= '0; m_imm <= '0; m_ctrl <= '0;
            m_bubbles <= 0;
        end else if (flush || model_hz()) begin
            m_valid <= 1'b0; m_ctrl <= '0; m_rs <= '0; m_rt <= '0; m_rd <= '0;
            m_bubbles <= m_bubbles + 1;
        end else begin
            m_valid <= id_valid;
            m_ctrl  <= id_valid ? id_ctrl : 8'h00;
            m_rs <= id_rs; m_rt <= id_rt; m_rd <= id_rd;
            m_rs_data <= id_rs_data; m_rt_data <= id_rt_data; m_imm <= id_imm;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model, away from the clock edge
    always @(negedge clk) begin
        cyc++;
        check("stall",   64'(stall),        64'(model_stall()));
        check("valid",   64'(idex_valid),   64'(m_valid));
        check("rs",      64'(idex_rs),      64'(m_rs));
        check("rt",      64'(idex_rt),      64'(m_rt));
        check("rd",      64'(idex_rd),      64'(m_rd));
        check("ctrl",    64'(idex_ctrl),    64'(m_ctrl));
        check("rs_data", 64'(idex_rs_data), 64'(m_rs_data));
        check("rt_data", 64'(idex_rt_data), 64'(m_rt_data));
        check("imm",     64'(idex_imm),     64'(m_imm));
        check("cnt16",   64'(bubble_cnt),   64'(sat(m_bubbles, 65535)));
        check("s_stall", 64'(s_stall),      64'(model_stall()));
        check("s_valid", 64'(s_valid),      64'(m_valid));
        check("s_spec",  64'({s_rs, s_rt, s_rd}), 64'({m_rs, m_rt, m_rd}));
        check("s_ctrl",  64'(s_ctrl),       64'(m_ctrl));
        check("s_data",  64'({s_rs_data, s_rt_data}), 64'({m_rs_data, m_rt_data}));
        check("s_imm",   64'(s_imm),        64'(m_imm));
        check("cnt2",    64'(s_cnt),        64'(sat(m_bubbles, 3)));
        $display("cyc=%0d rst_n=%b flush=%b stall=%b valid=%b rs=%0d rt=%0d ctrl=%02h cnt=%0d cnt2=%0d",
                 cyc, rst_n, flush, stall, idex_valid, idex_rs, idex_rt, idex_ctrl, bubble_cnt, s_cnt);
    end

    // ---------------- stimulus ----------------
    localparam logic [7:0] C_LW   = 8'hD8;  // regwrite memread memtoreg alusrc
    localparam logic [7:0] C_ADD  = 8'h86;  // regwrite regdst aluop=10
    localparam logic [7:0] C_SW   = 8'h28;  // memwrite alusrc
    localparam logic [7:0] C_ADDI = 8'h88;  // regwrite alusrc

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic ur, input logic [7:0] c);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur; id_ctrl = c;
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic hold;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(idex_valid), 64'd0);
        check("rst_cnt",   64'(bubble_cnt), 64'd0);
        check("rst_stall", 64'(stall),      64'd0);
        #1 rst_n = 1'b1;

        // lw $5 followed by add $6,$5,$7: one stall, one bubble, then add enters EX
        step();
        set_id(1, 5'd1, 5'd5, 5'd0, 0, C_LW);
        #1 check("lw_nostall", 64'(stall), 64'd0);
        step();
        set_id(1, 5'd5, 5'd7, 5'd6, 1, C_ADD);
        #1 check("lu_stall", 64'(stall), 64'd1);
        step();
        check("lu_bub_valid", 64'(idex_valid), 64'd0);
        check("lu_bub_ctrl",  64'(idex_ctrl),  64'd0);
        check("lu_bub_cnt",   64'(bubble_cnt), 64'd1);
        check("lu_released",  64'(stall),      64'd0);
        step();
        check("add_valid", 64'(idex_valid), 64'd1);
        check("add_rs",    64'(idex_rs),    64'd5);
        check("add_ctrl",  64'(idex_ctrl),  64'(C_ADD));

        // lw $5 then sw rs=1 rt=5 (rt read) stalls; lw $5 then addi rt=5 does not
        set_id(1, 5'd1, 5'd5, 5'd0, 0, C_LW);
        step();
        set_id(1, 5'd1, 5'd5, 5'd0, 1, C_SW);
        #1 check("sw_stall", 64'(stall), 64'd1);
        step();
        check("sw_cnt", 64'(bubble_cnt), 64'd2);
        step();
        set_id(1, 5'd1, 5'd5, 5'd0, 0, C_LW);
        step();
        set_id(1, 5'd1, 5'd5, 5'd0, 0, C_ADDI);
        #1 check("addi_nostall", 64'(stall), 64'd0);
        step();
        check("addi_ctrl", 64'(idex_ctrl),  64'(C_ADDI));
        check("addi_cnt",  64'(bubble_cnt), 64'd2);

        // lw $0 never stalls
        set_id(1, 5'd1, 5'd0, 5'd0, 0, C_LW);
        step();
        set_id(1, 5'd0, 5'd0, 5'd6, 1, C_ADD);
        #1 check("r0_nostall", 64'(stall), 64'd0);
        step();
        check("r0_valid", 64'(idex_valid), 64'd1);
        check("r0_cnt",   64'(bubble_cnt), 64'd2);

        // flush coincident with hazard: no stall, one bubble, next ID taken
        set_id(1, 5'd1, 5'd5, 5'd0, 0, C_LW);
        step();
        set_id(1, 5'd5, 5'd7, 5'd6, 1, C_ADD);
        flush = 1'b1;
        #1 check("fl_stall", 64'(stall), 64'd0);
        step();
        check("fl_valid", 64'(idex_valid), 64'd0);
        check("fl_cnt",   64'(bubble_cnt), 64'd3);
        flush = 1'b0;
        set_id(1, 5'd2, 5'd3, 5'd4, 1, C_ADD);
        #1 check("fl_next_stall", 64'(stall), 64'd0);
        step();
        check("fl_next_rs", 64'(idex_rs), 64'd2);

        // three more bubbles: 6 total, 2-bit counter pinned at 3
        flush = 1'b1;
        step(); step(); step();
        flush = 1'b0;
        check("sat_cnt16", 64'(bubble_cnt), 64'd6);
        check("sat_cnt2",  64'(s_cnt),      64'd3);

        // reset asserted mid-stall
        set_id(1, 5'd1, 5'd5, 5'd0, 0, C_LW);
        step();
        set_id(1, 5'd5, 5'd5, 5'd6, 1, C_ADD);
        #1 check("pre_rst_stall", 64'(stall), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 64'(stall),      64'd0);
        check("mid_rst_valid", 64'(idex_valid), 64'd0);
        check("mid_rst_ctrl",  64'(idex_ctrl),  64'd0);
        check("mid_rst_rt",    64'(idex_rt),    64'd0);
        check("mid_rst_cnt",   64'(bubble_cnt), 64'd0);
        check("mid_rst_cnt2",  64'(s_cnt),      64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // random traffic; a stalled instruction is re-presented unchanged
        hold = 1'b0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (!hold) begin
                set_id(($urandom_range(0, 7) != 0),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                       8'($urandom));
            end
            flush = ($urandom_range(0, 7) == 0);
            #1 hold = model_stall();
        end
        step();
        flush = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
